// File: rtl/instr_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instr_encoder
// Purpose  : Two-stage RV32I encoder. Symbolic requests come in on a
//            valid/ready stream. 32-bit instruction words go out with an
//            auto-incrementing target address. Illegal requests produce a
//            flagged NOP.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  // Operation codes that bound each encoding format.
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_SLTU  = 6'd9;
  localparam logic [5:0] OP_SLTIU = 6'd15;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_LHU   = 6'd23;
  localparam logic [5:0] OP_SW    = 6'd26;
  localparam logic [5:0] OP_BGEU  = 6'd32;
  localparam logic [5:0] OP_JAL   = 6'd33;
  localparam logic [5:0] OP_JALR  = 6'd34;
  localparam logic [5:0] OP_LUI   = 6'd35;
  localparam logic [5:0] OP_AUIPC = 6'd36;

  // Major opcodes.
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  // Stage 1 holds the request. Only imm[20:0] is needed once legality is known.
  logic        s1_valid_q, s1_valid_d;
  logic        s1_err_q;
  logic [5:0]  s1_op_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [20:0] s1_imm_q;

  // Stage 2 drives the outputs.
  logic        out_valid_q;
  logic [31:0] out_word_q;
  logic        out_err_q;
  logic [31:0] out_addr_q;
  logic [7:0]  err_count_q;

  logic s2_load, s1_move, accept, out_xfer;
  logic fits12, fits13, fits21, shamt_ok, upper_ok, in_legal;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] raw_word, enc_word;

  assign s2_load  = !out_valid_q | out_ready;
  assign s1_move  = s1_valid_q & s2_load;
  assign in_ready = !s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready & !flush;
  assign out_xfer = out_valid_q & out_ready & !flush;

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;
  assign out_addr  = out_addr_q;
  assign err_count = err_count_q;

  // The immediate ranges reduce to checks that the upper bits are a pure
  // sign extension. Branch and JAL offsets must also be even.
  assign fits12   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits13   = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
  assign fits21   = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
  assign shamt_ok = (in_imm[31:5] == '0);
  assign upper_ok = (in_imm[31:20] == '0);

  // Legality of the incoming request, judged by its format.
  always_comb begin
    in_legal = 1'b0;
    if (in_op <= OP_SLTU)       in_legal = 1'b1;
    else if (in_op <= OP_SLTIU) in_legal = fits12;
    else if (in_op <= OP_SRAI)  in_legal = shamt_ok;
    else if (in_op <= OP_SW)    in_legal = fits12;
    else if (in_op <= OP_BGEU)  in_legal = fits13;
    else if (in_op == OP_JAL)   in_legal = fits21;
    else if (in_op == OP_JALR)  in_legal = fits12;
    else if (in_op <= OP_AUIPC) in_legal = upper_ok;
  end

  // Stage 1 next-valid: flush empties it, otherwise fill or hand off.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)        s1_valid_d = 1'b0;
    else if (accept)  s1_valid_d = 1'b1;
    else if (s1_move) s1_valid_d = 1'b0;
  end

  // Stage 1 register: capture the request and its legality on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_err_q <= !in_legal;
        s1_op_q  <= in_op;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_imm_q <= in_imm[20:0];
      end
    end
  end

  // funct3/funct7 lookup for the held operation.
  always_comb begin
    funct3 = 3'b000;
    case (s1_op_q)
      6'd2, 6'd11, 6'd32:                      funct3 = 3'b111;
      6'd3, 6'd12, 6'd31:                      funct3 = 3'b110;
      6'd4, 6'd13, 6'd22, 6'd29:               funct3 = 3'b100;
      6'd5, 6'd16, 6'd20, 6'd25, 6'd28:        funct3 = 3'b001;
      6'd6, 6'd7, 6'd17, 6'd18, 6'd23, 6'd30:  funct3 = 3'b101;
      6'd8, 6'd14, 6'd21, 6'd26:               funct3 = 3'b010;
      6'd9, 6'd15:                             funct3 = 3'b011;
      default:                                 funct3 = 3'b000;
    endcase
    funct7 = ((s1_op_q == OP_SUB) || (s1_op_q == OP_SRA) || (s1_op_q == OP_SRAI))
             ? 7'b0100000 : 7'b0000000;
  end

  // Assemble the word in the format implied by the operation.
  always_comb begin
    raw_word = NOP_WORD;
    if (s1_op_q <= OP_SLTU)
      raw_word = {funct7, s1_rs2_q, s1_rs1_q, funct3, s1_rd_q, OPC_REG};
    else if (s1_op_q <= OP_SLTIU)
      raw_word = {s1_imm_q[11:0], s1_rs1_q, funct3, s1_rd_q, OPC_IMM};
    else if (s1_op_q <= OP_SRAI)
      raw_word = {funct7, s1_imm_q[4:0], s1_rs1_q, funct3, s1_rd_q, OPC_IMM};
    else if (s1_op_q <= OP_LHU)
      raw_word = {s1_imm_q[11:0], s1_rs1_q, funct3, s1_rd_q, OPC_LOAD};
    else if (s1_op_q <= OP_SW)
      raw_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, funct3, s1_imm_q[4:0], OPC_STORE};
    else if (s1_op_q <= OP_BGEU)
      raw_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, funct3,
                  s1_imm_q[4:1], s1_imm_q[11], OPC_BRANCH};
    else if (s1_op_q == OP_JAL)
      raw_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                  s1_rd_q, OPC_JAL};
    else if (s1_op_q == OP_JALR)
      raw_word = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, OPC_JALR};
    else if (s1_op_q == OP_LUI)
      raw_word = {s1_imm_q[19:0], s1_rd_q, OPC_LUI};
    else if (s1_op_q == OP_AUIPC)
      raw_word = {s1_imm_q[19:0], s1_rd_q, OPC_AUIPC};
    enc_word = s1_err_q ? NOP_WORD : raw_word;
  end

  // Stage 2 register: output word, address counter and saturating error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      err_count_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
    end else begin
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_word_q <= enc_word;
          out_err_q  <= s1_err_q;
        end
      end
      if (out_xfer) begin
        out_addr_q <= out_addr_q + 32'd4;
        if (out_err_q && (err_count_q != 8'hFF))
          err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Scoreboard bench for instr_encoder. A reference encoder produces
//            expected words, and a monitor checks every output transfer.
//            A second instance with a high base address covers wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_word, out_addr;
  logic [7:0]  err_count;
  logic        w_in_ready, w_out_valid, w_out_err;
  logic [31:0] w_out_word, w_out_addr;
  logic [7:0]  w_err_count;

  always #5 clk = ~clk;

  instr_encoder u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.BASE_ADDR(WRAP_BASE)) u_wrap (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_word(w_out_word),
    .out_addr(w_out_addr), .out_err(w_out_err), .err_count(w_err_count)
  );

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] exp_addr;
  int          exp_errcnt;
  int          total = 0;
  int          bad   = 0;
  bit          rnd_ready = 0;

  // funct3 per operation code 0..36.
  int F3 [37] = '{0,0,7,6,4,1,5,5,2,3, 0,7,6,4,2,3,1,5,5, 0,1,2,4,5, 0,1,2,
                  0,1,4,5,6,7, 0,0,0,0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference encoder: legality from signed arithmetic ranges, then ISA field layout.
  function automatic logic [32:0] model(input int op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    int          v;
    bit          ok;
    logic [31:0] w;
    logic [2:0]  f3;
    v  = $signed(imm);
    f3 = (op < 37) ? 3'(F3[op]) : 3'd0;
    ok = 1'b1;
    w  = NOP;
    if (op <= 9)
      w = {(op == 1 || op == 7) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
    else if (op <= 15) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = {imm[11:0], rs1, f3, rd, 7'h13};
    end else if (op <= 18) begin
      ok = (v >= 0) && (v <= 31);
      w  = {(op == 18) ? 7'h20 : 7'h00, imm[4:0], rs1, f3, rd, 7'h13};
    end else if (op <= 23) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = {imm[11:0], rs1, f3, rd, 7'h03};
    end else if (op <= 26) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    end else if (op <= 32) begin
      ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    end else if (op == 33) begin
      ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    end else if (op == 34) begin
      ok = (v >= -2048) && (v <= 2047);
      w  = {imm[11:0], rs1, 3'b000, rd, 7'h67};
    end else if (op == 35 || op == 36) begin
      ok = (imm < 32'h0010_0000);
      w  = {imm[19:0], rd, (op == 35) ? 7'h37 : 7'h17};
    end else
      ok = 1'b0;
    return ok ? {1'b0, w} : {1'b1, NOP};
  endfunction

  function automatic logic [31:0] rnd_imm();
    int v;
    case ($urandom_range(0, 4))
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(0, 9999)) - 5000;
      2:       v = int'($urandom_range(0, 40));
      3:       v = int'($urandom_range(0, 2200000)) - 1100000;
      default: v = int'($urandom_range(0, 32'h0020_0000));
    endcase
    return 32'(v);
  endfunction

  task automatic push_exp(input logic [32:0] r);
    exp_t e;
    e.word = r[31:0];
    e.err  = r[32];
    sb_q.push_back(e);
  endtask

  task automatic set_rand_req(output logic [32:0] r);
    in_op  = 6'($urandom_range(0, 40));
    in_rd  = 5'($urandom);
    in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom);
    in_imm = rnd_imm();
    r = model(int'(in_op), in_rd, in_rs1, in_rs2, in_imm);
  endtask

  // Present one request until accepted (called and returns just after a rising edge).
  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [32:0] r);
    bit done = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        push_exp(r);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout: got no acceptance expected acceptance op=%0d", op);
    end
  endtask

  task automatic issue_model(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
    issue(op, rd, rs1, rs2, imm, model(int'(op), rd, rs1, rs2, imm));
  endtask

  task automatic issue_rand();
    logic [32:0] r;
    set_rand_req(r);
    issue(in_op, in_rd, in_rs1, in_rs2, in_imm, r);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !out_valid;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: queue=%0d expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_word"},  out_word, 32'd0);
    chk({tag, "_out_addr"},  out_addr, 32'd0);
    chk({tag, "_out_err"},   32'(out_err), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd1);
    chk({tag, "_wrap_addr"}, w_out_addr, WRAP_BASE);
  endtask

  // Random sink back-pressure.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: on every output transfer pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        sb_q.delete();
        exp_addr = 32'h0;
      end else if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %08h expected none", out_word);
        end else begin
          mon_e = sb_q.pop_front();
          chk("word", out_word, mon_e.word);
          chk("err", 32'(out_err), 32'(mon_e.err));
          chk("addr", out_addr, exp_addr);
          chk("err_count", 32'(err_count), 32'(exp_errcnt));
          chk("wrap_addr", w_out_addr, exp_addr + WRAP_BASE);
          chk("wrap_word", w_out_word, mon_e.word);
          exp_addr = exp_addr + 32'd4;
          if (mon_e.err && exp_errcnt < 255) exp_errcnt++;
        end
      end
    end
  end

  logic [32:0] bp_r;
  int          bp_acc;
  bit          bp_take;
  logic [31:0] held_w, held_a;
  logic [7:0]  ec_before;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = 32'h0; exp_errcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ADDI/ADD/SUB with a latency and throughput watcher.
    out_ready = 1'b1;
    fork
      begin
        issue(6'd10, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h0050_0093});
        issue(6'd0,  5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h0020_81B3});
        issue(6'd1,  5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h4020_81B3});
      end
      begin
        @(negedge clk);
        @(negedge clk); chk("lat_one_cycle", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_two_cycles", 32'(out_valid), 32'd1);
        @(negedge clk); chk("throughput_2", 32'(out_valid), 32'd1);
        @(negedge clk); chk("throughput_3", 32'(out_valid), 32'd1);
      end
    join
    @(posedge clk); #1;
    drain();

    // Store, branch, jump, upper-immediate formats.
    issue(6'd26, 5'd7, 5'd1, 5'd2, 32'd8,          {1'b0, 32'h0020_A423});
    issue(6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  {1'b0, 32'hFE20_8EE3});
    issue(6'd33, 5'd1, 5'd0, 5'd0, 32'd8,          {1'b0, 32'h0080_00EF});
    issue(6'd35, 5'd5, 5'd0, 5'd0, 32'h0001_2345,  {1'b0, 32'h1234_52B7});
    drain();

    // Illegal requests become flagged NOPs.
    issue(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048, {1'b1, NOP});
    issue(6'd27, 5'd1, 5'd1, 5'd2, 32'd3,    {1'b1, NOP});
    issue(6'd40, 5'd1, 5'd1, 5'd2, 32'd0,    {1'b1, NOP});
    drain();
    chk("err_count_three", 32'(err_count), 32'd3);

    // Back-pressure: sink stalled for five cycles with requests pending.
    out_ready = 1'b0;
    bp_acc = 0;
    set_rand_req(bp_r);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bp_take = in_ready;
      if (bp_take) begin
        push_exp(bp_r);
        bp_acc++;
      end
      if (c == 2) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        held_w = out_word;
        held_a = out_addr;
      end
      if (c > 2) begin
        chk("bp_word_stable", out_word, held_w);
        chk("bp_addr_stable", out_addr, held_a);
      end
      @(posedge clk); #1;
      if (bp_take) set_rand_req(bp_r);
    end
    chk("bp_accepted", 32'(bp_acc), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    if (in_ready) push_exp(bp_r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Flush with both stages full; the request in the flush cycle is dropped.
    out_ready = 1'b0;
    issue_model(6'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    issue_model(6'd63, 5'd1, 5'd2, 5'd3, 32'd0);
    ec_before = err_count;
    flush = 1'b1;
    in_valid = 1'b1; in_op = 6'd10; in_imm = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_err_count", 32'(err_count), 32'(ec_before));
    chk("flush_addr", out_addr, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue_model(6'd12, 5'd4, 5'd5, 5'd0, 32'h0000_07FF);
    drain();
    chk("flush_wrap_reloaded", w_out_addr, WRAP_BASE + 32'd4);

    // Randomized traffic with random sink stalls.
    rnd_ready = 1'b1;
    repeat (200) issue_rand();
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;

    // Error counter saturation.
    repeat (260) issue(6'd63, 5'd0, 5'd0, 5'd0, 32'd0, {1'b1, NOP});
    drain();
    chk("err_count_saturated", 32'(err_count), 32'd255);

    // Asynchronous reset in the middle of traffic.
    rnd_ready = 1'b1;
    repeat (6) issue_rand();
    @(posedge clk); #3;
    reset_n = 1'b0;
    rnd_ready = 1'b0;
    #1;
    chk_reset_state("midreset");
    sb_q.delete();
    exp_addr = 32'h0;
    exp_errcnt = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rnd_ready = 1'b1;
    repeat (60) issue_rand();
    drain();
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
